// File: rtl/spi_master_ctrl.sv
// SPI master on the picoRV32 shared memory bus.
// Register window: DATA (+0x0), CTRL (+0x4), STATUS (+0x8), reserved (+0xC).
// Supports configurable word width, SCLK divider, all CPOL/CPHA modes,
// MSB/LSB-first order and multiple chip selects.
module spi_master_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WIDTH     = 8,
    parameter int          NUM_CS    = 1,
    parameter int          DIV_WIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              wen,
    input  logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_port_ready,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int ECW = $clog2(2 * WIDTH) + 1;
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t               state;
    logic                 cpol, cpha, lsb_first;
    logic [2:0]           cs_idx;
    logic [DIV_WIDTH-1:0] div;
    logic                 done, overrun;
    logic [WIDTH-1:0]     rx, tx_sh, rx_sh;
    logic [DIV_WIDTH-1:0] hcnt;
    logic [ECW-1:0]       ecnt;

    logic                 hit, acc, start, ctrl_wr, data_ovr, status_rd, tick;
    logic                 leading, sample_edge, shift_edge;
    logic [1:0]           offset;
    logic [31:0]          read_val;
    logic                 unused_bits;

    // Bus addresses are word aligned; low address bits carry no meaning here.
    assign unused_bits = ^{addr[1:0], wdata};

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b,
                                                 input logic lsb);
        return lsb ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    // An out-of-range index selects no line at all.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [2:0] idx);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (3'(i) == idx) m[i] = 1'b0;
        end
        return m;
    endfunction

    // Address decode, access strobes, read mux and SCLK edge classification.
    always_comb begin
        offset      = addr[3:2];
        hit         = mem_valid && (addr[31:4] == BASE_ADDR[31:4]);
        acc         = hit && !mem_port_ready && !mem_ready;
        start       = acc && wen && (offset == 2'd0) && !busy;
        data_ovr    = acc && wen && (offset == 2'd0) && busy;
        ctrl_wr     = acc && wen && (offset == 2'd1) && !busy;
        status_rd   = acc && !wen && (offset == 2'd2);
        tick        = (hcnt == div);
        leading     = !ecnt[0];
        sample_edge = (leading == !cpha);
        shift_edge  = !sample_edge && (cpha ? (ecnt != '0) : (ecnt != LAST_EDGE));
        read_val    = '0;
        case (offset)
            2'd0: read_val[WIDTH-1:0] = rx;
            2'd1: begin
                read_val[0]              = cpol;
                read_val[1]              = cpha;
                read_val[2]              = lsb_first;
                read_val[10:8]           = cs_idx;
                read_val[16 +: DIV_WIDTH] = div;
            end
            2'd2: read_val[2:0] = {overrun, done, busy};
            default: read_val = '0;
        endcase
    end

    // Bus acknowledge, read data capture, CTRL register and overrun flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_port_ready <= 1'b0;
            rdata          <= '0;
            cpol           <= 1'b0;
            cpha           <= 1'b0;
            lsb_first      <= 1'b0;
            cs_idx         <= '0;
            div            <= '0;
            overrun        <= 1'b0;
        end else begin
            mem_port_ready <= acc;
            if (acc) rdata <= wen ? 32'd0 : read_val;
            if (ctrl_wr) begin
                cpol      <= wdata[0];
                cpha      <= wdata[1];
                lsb_first <= wdata[2];
                cs_idx    <= wdata[10:8];
                div       <= wdata[16 +: DIV_WIDTH];
            end
            if (data_ovr) overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
        end
    end

    // Transfer sequencer: SETUP, 2*WIDTH sclk edges, HOLD; owns all SPI pins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rx    <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            hcnt  <= '0;
            ecnt  <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            cs_n  <= '1;
        end else begin
            // Status read clears done; a completion on the same edge overrides below.
            if (status_rd) done <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk <= cpol;
                    cs_n <= '1;
                    if (start) begin
                        state <= S_SETUP;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        cs_n  <= cs_decode(cs_idx);
                        hcnt  <= '0;
                        ecnt  <= '0;
                        rx_sh <= '0;
                        mosi  <= first_bit(wdata[WIDTH-1:0], lsb_first);
                        tx_sh <= shift_out(wdata[WIDTH-1:0], lsb_first);
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        hcnt  <= '0;
                        state <= S_SHIFT;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        hcnt <= '0;
                        sclk <= ~sclk;
                        ecnt <= ecnt + ECW'(1);
                        if (sample_edge) rx_sh <= shift_in(rx_sh, miso, lsb_first);
                        if (shift_edge) begin
                            mosi  <= first_bit(tx_sh, lsb_first);
                            tx_sh <= shift_out(tx_sh, lsb_first);
                        end
                        if (ecnt == LAST_EDGE) state <= S_HOLD;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        hcnt  <= '0;
                        state <= S_IDLE;
                        cs_n  <= '1;
                        rx    <= rx_sh;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: bus reads and SPI transfers are
// predicted when issued and checked by independent monitors.
module tb_spi_master_ctrl;

    localparam int          W    = 8;
    localparam int          NCS  = 4;
    localparam int          DW   = 8;
    localparam logic [31:0] BASE = 32'h0300_0040;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [31:0]    addr = '0, wdata = '0;
    logic           wen = 1'b0, mem_valid = 1'b0, mem_ready = 1'b0;
    logic           mem_port_ready;
    logic [31:0]    rdata;
    logic           busy, sclk, mosi, miso;
    logic [NCS-1:0] cs_n;

    logic           loop_en = 1'b1;
    logic           slave_bit = 1'b0;
    logic [W-1:0]   slave_pat = '0;
    assign miso = loop_en ? mosi : slave_bit;

    spi_master_ctrl #(.BASE_ADDR(BASE), .WIDTH(W), .NUM_CS(NCS), .DIV_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .wdata(wdata), .wen(wen),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_port_ready(mem_port_ready),
        .rdata(rdata), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference configuration as last successfully written.
    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
    logic [2:0] m_cs = '0;
    int         m_div = 0;

    // Expected bus responses and expected transfers.
    bit             bq_chk[$];
    logic [31:0]    bq_val[$];
    string          bq_nm[$];
    int             xq_len[$];
    logic [NCS-1:0] xq_cs[$];
    logic [W-1:0]   xq_tx[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Bus monitor: every acknowledge consumes one predicted response.
    bit          mon_chk;
    logic [31:0] mon_val;
    string       mon_nm;
    always @(negedge clk) begin
        if (mem_port_ready) begin
            if (bq_val.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with rdata 0x%08h, required none", rdata);
            end else begin
                mon_chk = bq_chk.pop_front();
                mon_val = bq_val.pop_front();
                mon_nm  = bq_nm.pop_front();
                if (mon_chk) check(mon_nm, rdata, mon_val);
            end
        end
    end

    // SPI monitor plus slave: watches sclk edges, rebuilds the sent word,
    // and drives the slave pattern so bit k is stable before sample edge k.
    bit             in_x = 0;
    int             x_len, x_edges, x_bits = 0, idx;
    logic [NCS-1:0] x_cs;
    logic [W-1:0]   x_word;
    bit             x_csbad, lead;
    logic           prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            in_x   = 0;
            x_bits = 0;
        end else begin
            if (busy && !in_x) begin
                in_x = 1; x_len = 0; x_edges = 0; x_bits = 0;
                x_cs = cs_n; x_word = '0; x_csbad = 0;
            end
            if (busy) begin
                x_len++;
                if (cs_n !== x_cs) x_csbad = 1;
                if (sclk !== prev_sclk) begin
                    x_edges++;
                    lead = (prev_sclk == m_cpol);
                    if (lead == !m_cpha) begin
                        if (x_bits < W) begin
                            if (m_lsb) x_word[x_bits] = mosi;
                            else       x_word[W-1-x_bits] = mosi;
                        end
                        x_bits++;
                    end
                end
            end else if (in_x) begin
                in_x = 0;
                if (xq_len.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got transfer of %0d cycles, required none", x_len);
                end else begin
                    check("xfer_len", x_len, xq_len.pop_front());
                    check("xfer_cs", 32'(x_cs), 32'(xq_cs.pop_front()));
                    check("xfer_cs_stable", 32'(x_csbad), 32'd0);
                    check("xfer_edges", x_edges, 2 * W);
                    check("xfer_mosi", 32'(x_word), 32'(xq_tx.pop_front()));
                    check("sclk_idle", 32'(sclk), 32'(m_cpol));
                end
            end
        end
        prev_sclk = sclk;
        idx = (in_x && x_bits < W) ? x_bits : 0;
        slave_bit = m_lsb ? slave_pat[idx] : slave_pat[W-1-idx];
    end

    // One bus access; called and returns 1 time unit after a rising edge.
    task automatic bus(input logic [1:0] off, input logic w, input logic [31:0] d,
                       input bit chk, input logic [31:0] exp, input string nm);
        bit got;
        got = 0;
        bq_chk.push_back(chk); bq_val.push_back(exp); bq_nm.push_back(nm);
        addr = BASE | {28'd0, off, 2'b00}; wen = w; wdata = d; mem_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_port_ready) begin got = 1; break; end
        end
        mem_valid = 1'b0; wen = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no acknowledge, required one", nm);
            void'(bq_chk.pop_back()); void'(bq_val.pop_back()); void'(bq_nm.pop_back());
        end
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string nm);
        bus(off, 1'b0, 32'd0, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input string nm);
        bus(off, 1'b1, d, 1'b0, 32'd0, nm);
    endtask

    function automatic logic [31:0] ctrl_word(input logic pol, input logic pha, input logic lsb,
                                              input logic [2:0] cs, input int dv);
        logic [31:0] v;
        v = '0;
        v[0] = pol; v[1] = pha; v[2] = lsb; v[10:8] = cs;
        v[16 +: DW] = DW'(dv);
        return v;
    endfunction

    task automatic write_ctrl(input logic pol, input logic pha, input logic lsb,
                              input logic [2:0] cs, input int dv);
        wr(2'd1, ctrl_word(pol, pha, lsb, cs, dv), "ctrl_wr");
        m_cpol = pol; m_cpha = pha; m_lsb = lsb; m_cs = cs; m_div = dv;
        rd(2'd1, ctrl_word(pol, pha, lsb, cs, dv), "ctrl_readback");
    endtask

    task automatic start_xfer(input logic [W-1:0] tx, input bit expect_it);
        logic [NCS-1:0] cs;
        cs = '1;
        if (int'(m_cs) < NCS) cs[m_cs] = 1'b0;
        if (expect_it) begin
            xq_len.push_back((2 * W + 2) * (m_div + 1));
            xq_cs.push_back(cs);
            xq_tx.push_back(tx);
        end
        wr(2'd0, 32'(tx), "data_wr");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 after 3000 cycles, required 0");
        end
    endtask

    task automatic finish_xfer(input logic [W-1:0] exp_rx);
        wait_idle();
        rd(2'd0, 32'(exp_rx), "data_rx");
        rd(2'd2, 32'h2, "status_done");
        rd(2'd2, 32'h0, "status_cleared");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] tx;
        int           mode;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(mem_port_ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        resetn = 1'b1;
        @(posedge clk); #1;
        rd(2'd1, 32'd0, "ctrl_rst");
        rd(2'd0, 32'd0, "rx_rst");
        rd(2'd2, 32'd0, "status_rst");
        rd(2'd3, 32'd0, "reserved_rd");

        // Address outside the window is never acknowledged.
        addr = BASE + 32'h10; wen = 1'b0; mem_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("miss_noack", 32'(mem_port_ready), 32'd0);
        end
        mem_valid = 1'b0;

        // Mode 0 loopback.
        loop_en = 1'b1;
        write_ctrl(1'b0, 1'b0, 1'b0, 3'd0, 1);
        start_xfer(8'hA5, 1);
        finish_xfer(8'hA5);

        // Modes 1..3 against a slave pattern.
        loop_en = 1'b0;
        slave_pat = 8'h3C;
        for (int m = 1; m < 4; m++) begin
            write_ctrl(1'(m >> 1), 1'(m & 1), 1'b0, 3'd0, 1);
            check("sclk_idle_cpol", 32'(sclk), 32'(m_cpol));
            start_xfer(8'hFF, 1);
            finish_xfer(8'h3C);
        end

        // LSB first.
        loop_en = 1'b1;
        write_ctrl(1'b0, 1'b0, 1'b1, 3'd0, 1);
        start_xfer(8'h01, 1);
        check("first_bit_lsb", 32'(mosi), 32'd1);
        finish_xfer(8'h01);

        // Overrun and CTRL write while busy.
        write_ctrl(1'b0, 1'b0, 1'b0, 3'd0, 1);
        start_xfer(8'h11, 1);
        wr(2'd0, 32'h22, "data_wr_busy");
        rd(2'd2, 32'h5, "status_overrun_busy");
        wr(2'd1, ctrl_word(1'b0, 1'b0, 1'b0, 3'd0, 7), "ctrl_wr_busy");
        rd(2'd1, ctrl_word(1'b0, 1'b0, 1'b0, 3'd0, 1), "ctrl_kept");
        finish_xfer(8'h11);

        // Chip-select selection, including an out-of-range index.
        write_ctrl(1'b0, 1'b0, 1'b0, 3'd2, 1);
        start_xfer(8'h5A, 1);
        finish_xfer(8'h5A);
        write_ctrl(1'b0, 1'b0, 1'b0, 3'd5, 1);
        start_xfer(8'hC3, 1);
        finish_xfer(8'hC3);

        // Randomised configurations and data.
        for (int it = 0; it < 12; it++) begin
            loop_en   = 1'($urandom_range(0, 1));
            slave_pat = W'($urandom);
            tx        = W'($urandom);
            mode      = int'($urandom_range(0, 3));
            write_ctrl(1'(mode >> 1), 1'(mode & 1), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            start_xfer(tx, 1);
            finish_xfer(loop_en ? tx : slave_pat);
        end

        // Reset in the middle of a transfer, with a concurrent blocked bus hit.
        loop_en = 1'b1;
        write_ctrl(1'b1, 1'b0, 1'b0, 3'd0, 1);
        start_xfer(8'h96, 0);
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0; addr = BASE; wen = 1'b0; mem_valid = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_cs = '0; m_div = 0;
        check("abort_cs_n", 32'(cs_n), 32'hF);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(mem_port_ready), 32'd0);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("ack_blocked_by_mem_ready", 32'(mem_port_ready), 32'd0);
        end
        mem_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        rd(2'd1, 32'd0, "ctrl_after_abort");
        rd(2'd0, 32'd0, "rx_after_abort");
        rd(2'd2, 32'd0, "status_after_abort");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(bq_val.size() + xq_len.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Memory-mapped SPI master for the picoRV32 SoC bus. It is the parametrised successor of the single-byte loopback SPI port. It adds configurable word width, SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first order, multiple chip selects, a real MISO shift path, and sticky status flags. It sits on the shared mem_valid/mem_ready bus alongside the other peripherals.

Parameters:
BASE_ADDR, 32'h0000_0000, base of the 16-byte register window; bits [3:0] must be zero.
WIDTH, 8, bits per transfer (2..32).
NUM_CS, 1, number of chip-select lines (1..8).
DIV_WIDTH, 8, width of the SCLK divider field (1..16).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
addr  in  32  bus byte address
wdata  in  32  bus write data
wen  in  1  high = write access
mem_valid  in  1  bus request valid
mem_ready  in  1  ready already driven by another peripheral this cycle
mem_port_ready  out  1  one-cycle acknowledge from this block
rdata  out  32  read data, valid while mem_port_ready=1
busy  out  1  transfer in progress
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Decode: hit = mem_valid && addr[31:4]==BASE_ADDR[31:4]. Offset addr[3:2]: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved.
- Access strobe acc = hit && !mem_port_ready && !mem_ready. On acc, mem_port_ready=1 for exactly the next cycle. Register writes and read side effects take effect on the acc edge. rdata is registered with mem_port_ready. The reserved offset reads 0, ignores writes and is still acknowledged.
- CTRL (R/W): [0] CPOL, [1] CPHA, [2] LSB_FIRST, [10:8] cs index, [16+DIV_WIDTH-1:16] DIV. Writes while busy=1 are ignored and still acknowledged.
- DATA write while idle: latch wdata[WIDTH-1:0] and start a transfer. Clear done.
- DATA write while busy: data is dropped and overrun=1.
- DATA read: returns rx register, zero-extended.
- STATUS read: returns {29'b0, overrun, done, busy}, then clears done and overrun. If a set event occurs on the same edge, the set wins.
- Half-period H = DIV+1 clk cycles. DIV=0 gives sclk = clk/2.
- FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE:
  - IDLE: sclk=CPOL, cs_n all 1, mosi holds its last value. Transfer start moves to SETUP on the same edge, sets busy=1, drives cs_n[index]=0 and puts the first bit on mosi.
  - SETUP: lasts H cycles.
  - SHIFT: 2*WIDTH sclk edges spaced H apart. CPHA=0: sample miso on odd (leading) edges, shift mosi on even (trailing) edges, except after the last bit. CPHA=1: shift mosi on leading edges (the first leading edge drives bit 0), sample on trailing edges.
  - HOLD: lasts H cycles with sclk=CPOL. At its end, cs_n returns to all 1, rx is updated with the shifted-in word, busy=0, done=1 on the same edge.
- busy is high for exactly (2*WIDTH+2)*H cycles.
- Bit order: LSB_FIRST=0 sends and receives MSB first; LSB_FIRST=1 sends and receives LSB first. rx always holds the word in natural bit order.
- A cs index >= NUM_CS asserts no chip select; the transfer still runs and completes.
- Reset values, including reset mid-transfer (aborts immediately, rx unchanged from reset):
  - Outputs: mem_port_ready=0, rdata=0, busy=0, sclk=0, mosi=0, cs_n all 1.
  - Registers: CTRL=0, rx=0, done=0, overrun=0, state IDLE.

Test Plan:
1. WIDTH=8, CTRL=DIV 1 mode 0; write DATA 0xA5 with miso looped to mosi -> cs_n[0] low for 36 cycles, 8 rising sclk edges, mosi shows 1,0,1,0,0,1,0,1; DATA read = 0xA5; STATUS read = 0x2, second STATUS read = 0x0.
2. Modes 1, 2, 3 each with miso tied to slave pattern 0x3C, tx 0xFF -> rx 0x3C in every mode; sclk idles at CPOL between transfers.
3. LSB_FIRST=1, tx 0x01 -> first mosi bit 1 then seven 0s; loopback rx = 0x01.
4. DATA write 0x11 then DATA write 0x22 during busy -> only 0x11 is shifted, STATUS = 0x5 while busy (overrun+busy), CTRL write of DIV=7 during busy leaves DIV=1.
5. NUM_CS=4, cs index 2 -> only cs_n[2] low; cs index 5 -> no cs_n asserted, busy still 36 cycles, done set.
6. Deassert resetn mid-SHIFT -> next cycle cs_n=all 1, sclk=0, busy=0, CTRL=0; concurrent bus hit with mem_ready=1 -> mem_port_ready stays 0.
